// File: rtl/minimig_autoconfig_pkg.sv
// Shared definitions for the autoconfig chain: register offsets, FSM states
// and the per-slot identity descriptors presented through the config ROM.
package minimig_autoconfig_pkg;

  // Largest chain supported by the descriptor tables below.
  localparam int MAX_BOARDS = 8;

  // Byte offsets inside the $E80000 config space.
  localparam logic [7:0] OFS_TYPE     = 8'h00;
  localparam logic [7:0] OFS_SIZE     = 8'h02;
  localparam logic [7:0] OFS_PROD_HI  = 8'h04;
  localparam logic [7:0] OFS_PROD_LO  = 8'h06;
  localparam logic [7:0] OFS_MFG_3    = 8'h10;
  localparam logic [7:0] OFS_MFG_2    = 8'h12;
  localparam logic [7:0] OFS_MFG_1    = 8'h14;
  localparam logic [7:0] OFS_MFG_0    = 8'h16;
  localparam logic [7:0] OFS_FLAGS_HI = 8'h40;
  localparam logic [7:0] OFS_FLAGS_LO = 8'h42;
  localparam logic [7:0] OFS_BASE_Z3  = 8'h44;
  localparam logic [7:0] OFS_BASE_Z2  = 8'h48;
  localparam logic [7:0] OFS_BASE_LO  = 8'h4A;
  localparam logic [7:0] OFS_SHUTUP   = 8'h4C;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SCAN,
    ST_ACTIVE,
    ST_DONE
  } ac_state_t;

  // Per-slot descriptors, slot 0 in the least significant field.
  localparam logic [MAX_BOARDS*8-1:0]  PRODUCT_TBL = 64'h58_57_56_55_54_53_52_51;
  localparam logic [MAX_BOARDS*16-1:0] MFG_TBL     = {MAX_BOARDS{16'h1388}};
  localparam logic [MAX_BOARDS*32-1:0] SERIAL_TBL  = {MAX_BOARDS{32'h4D49_4E49}};
  localparam logic [MAX_BOARDS*8-1:0]  FLAGS_TBL   = {MAX_BOARDS{8'h30}};

  function automatic logic [7:0] slot_product(input logic [2:0] s);
    return PRODUCT_TBL[{s, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] slot_mfg(input logic [2:0] s);
    return MFG_TBL[{s, 4'b0000} +: 16];
  endfunction

  function automatic logic [7:0] slot_flags(input logic [2:0] s);
    return FLAGS_TBL[{s, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/minimig_autoconfig_rom.sv
// Combinational config ROM: returns the nibble for one slot at one offset,
// already inverted where the autoconfig protocol stores fields complemented.
module minimig_autoconfig_rom
  import minimig_autoconfig_pkg::*;
(
  input  logic [2:0] slot,
  input  logic [7:0] offset,
  input  logic [3:0] size,
  input  logic       zorro3,
  output logic [3:0] nibble
);

  logic [7:0]  product;
  logic [15:0] mfg;
  logic [7:0]  flags;
  logic [3:0]  raw;
  logic        true_ofs;

  // Nibble lookup; only type, size and flag nibbles are stored uninverted.
  always_comb begin
    product  = slot_product(slot);
    mfg      = slot_mfg(slot);
    flags    = slot_flags(slot);
    raw      = 4'h0;
    true_ofs = 1'b0;
    case (offset)
      OFS_TYPE:     begin raw = zorro3 ? 4'b1000 : 4'b1100; true_ofs = 1'b1; end
      // size code field; its MSB is the chained-board bit
      OFS_SIZE:     begin raw = size; true_ofs = 1'b1; end
      OFS_PROD_HI:  raw = product[7:4];
      OFS_PROD_LO:  raw = product[3:0];
      OFS_MFG_3:    raw = mfg[15:12];
      OFS_MFG_2:    raw = mfg[11:8];
      OFS_MFG_1:    raw = mfg[7:4];
      OFS_MFG_0:    raw = mfg[3:0];
      OFS_FLAGS_HI: begin raw = flags[7:4]; true_ofs = 1'b1; end
      OFS_FLAGS_LO: begin raw = flags[3:0]; true_ofs = 1'b1; end
      default:      raw = 4'h0;
    endcase
    nibble = true_ofs ? raw : ~raw;
  end

endmodule

// File: rtl/minimig_autoconfig_chain.sv
// Autoconfig chain controller: walks the enabled slots one at a time, serves
// the active slot's config ROM and records the base address the OS assigns.
module minimig_autoconfig_chain
  import minimig_autoconfig_pkg::*;
#(
  parameter int NUM_BOARDS = 3,
  parameter int IDX_W      = $clog2(NUM_BOARDS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk7_en,
  input  logic [6:0]              address_in,
  input  logic [15:0]             data_in,
  output logic [15:0]             data_out,
  input  logic                    rd,
  input  logic                    hwr,
  input  logic                    lwr,
  input  logic                    sel,
  input  logic [NUM_BOARDS-1:0]   board_enable,
  input  logic [4*NUM_BOARDS-1:0] board_size,
  input  logic [NUM_BOARDS-1:0]   board_zorro3,
  output logic [NUM_BOARDS-1:0]   board_configured,
  output logic [16*NUM_BOARDS-1:0] board_base,
  output logic [IDX_W-1:0]        active_board,
  output logic                    autoconfig_done
);

  ac_state_t                state_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [NUM_BOARDS-1:0]    en_reg;
  logic [NUM_BOARDS-1:0]    z3_reg;
  logic [4*NUM_BOARDS-1:0]  size_reg;
  logic [NUM_BOARDS-1:0]    cfg_reg;
  logic [16*NUM_BOARDS-1:0] base_reg;
  logic [3:0]               pend_reg;
  logic                     wr_prev_reg;
  logic                     done_reg;
  logic [15:0]              data_out_reg;

  logic [NUM_BOARDS-1:0]    slot_hit;
  logic                     cur_en;
  logic                     cur_z3;
  logic [3:0]               cur_size;
  logic [7:0]               offset;
  logic                     wr_strobe;
  logic                     wr_event;
  logic [2:0]               rom_slot;
  logic [3:0]               rom_nibble;

  // One-hot decode of the current slot index; the null index hits nothing.
  for (genvar gi = 0; gi < NUM_BOARDS; gi++) begin : g_hit
    assign slot_hit[gi] = (idx_reg == IDX_W'(gi));
  end

  assign offset    = {address_in, 1'b0};
  assign wr_strobe = sel & (hwr | lwr);
  assign wr_event  = clk7_en & wr_strobe & ~wr_prev_reg;
  assign rom_slot  = 3'(idx_reg);

  // Select the latched attributes of the current slot.
  always_comb begin
    cur_en   = |(en_reg & slot_hit);
    cur_z3   = |(z3_reg & slot_hit);
    cur_size = 4'h0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (slot_hit[i]) cur_size = size_reg[i*4 +: 4];
    end
  end

  minimig_autoconfig_rom u_rom (
    .slot   (rom_slot),
    .offset (offset),
    .size   (cur_size),
    .zorro3 (cur_z3),
    .nibble (rom_nibble)
  );

  // Strobe history for edge detection, advanced only on bus-cycle enables.
  always_ff @(posedge clk) begin
    if (reset) wr_prev_reg <= 1'b0;
    else if (clk7_en) wr_prev_reg <= wr_strobe;
  end

  // Chain FSM plus the configured/base registers it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      idx_reg   <= '0;
      en_reg    <= '0;
      z3_reg    <= '0;
      size_reg  <= '0;
      cfg_reg   <= '0;
      base_reg  <= '0;
      pend_reg  <= 4'h0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          en_reg    <= board_enable;
          z3_reg    <= board_zorro3;
          size_reg  <= board_size;
          idx_reg   <= '0;
          pend_reg  <= 4'h0;
          state_reg <= ST_SCAN;
        end
        ST_SCAN: begin
          if (idx_reg == IDX_W'(NUM_BOARDS)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else if (cur_en) begin
            state_reg <= ST_ACTIVE;
          end else begin
            idx_reg  <= idx_reg + IDX_W'(1);
            pend_reg <= 4'h0;
          end
        end
        ST_ACTIVE: begin
          if (wr_event) begin
            case (offset)
              OFS_BASE_LO: pend_reg <= data_in[15:12];
              OFS_BASE_Z2: begin
                if (!cur_z3) begin
                  for (int i = 0; i < NUM_BOARDS; i++) begin
                    if (slot_hit[i]) begin
                      base_reg[i*16 +: 16] <= {8'h00, data_in[15:12], pend_reg};
                      cfg_reg[i]           <= 1'b1;
                    end
                  end
                  idx_reg   <= idx_reg + IDX_W'(1);
                  pend_reg  <= 4'h0;
                  state_reg <= ST_SCAN;
                end
              end
              OFS_BASE_Z3: begin
                if (cur_z3) begin
                  for (int i = 0; i < NUM_BOARDS; i++) begin
                    if (slot_hit[i]) begin
                      base_reg[i*16 +: 16] <= data_in;
                      cfg_reg[i]           <= 1'b1;
                    end
                  end
                  idx_reg   <= idx_reg + IDX_W'(1);
                  pend_reg  <= 4'h0;
                  state_reg <= ST_SCAN;
                end
              end
              OFS_SHUTUP: begin
                idx_reg   <= idx_reg + IDX_W'(1);
                pend_reg  <= 4'h0;
                state_reg <= ST_SCAN;
              end
              default: ;
            endcase
          end
        end
        ST_DONE: done_reg <= 1'b1;
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  // Registered read path; nothing is presented outside ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) data_out_reg <= 16'h0000;
    else if (sel && rd)
      data_out_reg <= (state_reg == ST_ACTIVE) ? {rom_nibble, 12'hFFF} : 16'hFFFF;
    else data_out_reg <= 16'h0000;
  end

  assign data_out         = data_out_reg;
  assign board_configured = cfg_reg;
  assign board_base       = base_reg;
  assign active_board     = idx_reg;
  assign autoconfig_done  = done_reg;

endmodule

// File: doc/minimig_autoconfig_chain.md
# minimig_autoconfig_chain

Parametrised Zorro II/III autoconfig chain controller serving the $E80000 config space. It presents up to `NUM_BOARDS` virtual expansion boards in sequence and serves each board's nibble-wide, inverted config ROM. It latches the base address the OS writes, and handles shut-up (skip) requests. It drives per-board configured flags and base addresses to the address decoder, and asserts a done flag once the chain is exhausted.

## Interface
Parameters:
- `NUM_BOARDS`, 3, number of board slots in the chain (1..8).
- `IDX_W`, `$clog2(NUM_BOARDS+1)`, width of the board index, including the null index.

Ports (reset: reset, synchronous, active-high; clock: clk):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `clk7_en`  in  1  7 MHz bus-cycle enable; write strobes are sampled only when high.
- `address_in`  in  7  CPU A[7:1] within config space.
- `data_in`  in  16  CPU write data.
- `data_out`  out  16  read data; 0 when `sel` is low.
- `rd`  in  1  CPU read.
- `hwr`  in  1  CPU high-byte write.
- `lwr`  in  1  CPU low-byte write.
- `sel`  in  1  config space selected.
- `board_enable`  in  NUM_BOARDS  per-slot enable, sampled in INIT only.
- `board_size`  in  4*NUM_BOARDS  per-slot er_type size code, sampled in INIT only.
- `board_zorro3`  in  NUM_BOARDS  slot is a Zorro III board.
- `board_configured`  out  NUM_BOARDS  slot was assigned a base address.
- `board_base`  out  16*NUM_BOARDS  base A31..A16; Zorro II slots use [7:0] as A23..A16 and zero [15:8].
- `active_board`  out  IDX_W  current slot; equals NUM_BOARDS when the chain is exhausted.
- `autoconfig_done`  out  1  chain exhausted.

## Operation
- State machine: INIT -> SCAN -> ACTIVE -> SCAN ... -> DONE.
  - INIT: lasts one cycle. Latches `board_enable`, `board_size` and `board_zorro3`. Sets the index to 0. Goes to SCAN.
  - SCAN: checks one slot per cycle. If the slot is enabled, go to ACTIVE. Otherwise increment the index. When the index reaches NUM_BOARDS, go to DONE.
  - ACTIVE: serves the ROM for `active_board` and accepts writes.
  - DONE: `autoconfig_done`=1. Reads return 16'hFFFF when `sel` is high.
- ROM read, offset = {address_in,1'b0}:
  - The nibble is returned in `data_out[15:12]`, with `data_out[11:0]`=12'hFFF.
  - Offsets 0x00, 0x02, 0x40 and 0x42 are returned true. All other offsets are returned inverted.
  - Offset 0x00 holds {type bits, 0} and offset 0x02 holds {chain bit, size}; both are built from the latched size and the zorro3 flag. The remaining fields come from per-slot package constants.
  - Undefined offsets read as nibble 0, which is returned inverted as F.
- Write events:
  - A write event is the rising edge of `sel&(hwr|lwr)` sampled on a `clk7_en` cycle. A held strobe produces exactly one event.
  - Writes in INIT, SCAN or DONE are ignored.
- Writes in ACTIVE:
  - 0x4A: stores `data_in[15:12]` as the pending low nibble (A19..A16 for Zorro II).
  - 0x48, Zorro II slot: base = {`data_in[15:12]`, pending nibble}. Sets configured. Index+1. Goes to SCAN.
  - 0x44, Zorro III slot: base = `data_in[15:0]`. Sets configured. Index+1. Goes to SCAN.
  - 0x48 on a Zorro III slot and 0x44 on a Zorro II slot are ignored.
  - 0x4C (shut-up): configured stays 0, base stays 0. Index+1. Goes to SCAN.
- The pending nibble clears on every slot advance.

## Timing
- Reset values: `board_configured`=0, `board_base`=0, `active_board`=0, `autoconfig_done`=0, `data_out`=0. State after reset is INIT.
- `data_out` is registered: it reflects `address_in` and `sel` from the previous clk. A read therefore returns valid data 1 clk after the address is applied.
- A configuring write updates `board_configured`/`board_base` on the clk edge after the event. The next enabled slot becomes ACTIVE k+1 clks later, where k is the number of disabled slots skipped.
- All slots disabled: `autoconfig_done`=1 at NUM_BOARDS+2 clks after reset release.
- Reset asserted mid-operation: all configuration is lost and the chain restarts from slot 0. Enables are re-sampled.
- A write event during SCAN (between slots) is dropped. The OS re-reads before writing, so no write is lost in practice.
- Changes to `board_enable` after INIT have no effect until the next reset.

## Structure
- Package `minimig_autoconfig_pkg` holds:
  - register offset constants: 0x00, 0x02, 0x04, 0x06, 0x10, 0x12, 0x14, 0x16, 0x40, 0x42, 0x44, 0x48, 0x4A, 0x4C;
  - the state enum;
  - per-slot descriptor constants (product, manufacturer, serial, flags) and the max slot count of 8.
- Sub-module `minimig_autoconfig_rom` is a combinational nibble lookup with inputs (slot, offset, size, zorro3) and output the inversion-applied nibble.
- Top level contains the FSM, write-edge detect and base registers.

## Test plan
- Reset with enables 3'b111 and sizes {0,7,6}, slot 0 Zorro II. Read 0x00 and 0x02: the nibbles read from {type, size 6}, 0x04 reads inverted. Write 0x4A=0x0, then 0x48=0x2000. Expect `board_base[0]`=16'h0020, `board_configured`=3'b001, `active_board`=1 two clks later.
- Slot 1 Zorro III: write 0x44=0x4000. Expect `board_base[1]`=16'h4000. Then shut up slot 2 (write 0x4C). Expect `board_configured`=3'b011 and `autoconfig_done`=1. A read with `sel` high then returns 16'hFFFF.
- Enables 3'b100: `active_board`=2 at 4 clks after reset. Enables 3'b000: done at 5 clks after reset.
- Hold hwr for 10 `clk7_en` pulses at 0x48: exactly one slot advance.
- Assert reset after slot 0 is configured: all outputs return to reset values and slot 0 is served again.
- `sel` low during a read: `data_out`=0. A write to 0x48 on a Zorro III slot: no state change.
